// File: rtl/rf_exec_pkg.sv
// ---------------------------------------------------------------------------
// rf_exec_pkg
// Shared definitions for the regfile execution sequencer:
//   - default data/address widths (8-bit words, 8 registers)
//   - opcode encodings OP_ADD..OP_CMP
//   - FSM state encoding ST_IDLE..ST_RESP
//   - op_writes(): whether an opcode produces a register write-back
// ---------------------------------------------------------------------------
package rf_exec_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  localparam int OPW    = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_MOV = 3'd5;
  localparam logic [OPW-1:0] OP_LDI = 3'd6;
  localparam logic [OPW-1:0] OP_CMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // CMP only updates flags; every other opcode writes its result back.
  function automatic logic op_writes(input logic [OPW-1:0] op);
    return (op != OP_CMP);
  endfunction

endpackage

// File: rtl/rf_exec_alu.sv
// ---------------------------------------------------------------------------
// rf_exec_alu
// Purely combinational ALU for the regfile execution sequencer.
// Ports:
//   i_op      opcode (OP_ADD..OP_CMP)
//   i_a       operand A (value of rs)
//   i_b       operand B (value of rt)
//   i_imm     immediate, used by LDI only
//   o_result  DW-bit result, truncated (wraps mod 2^DW)
//   o_z       result == 0
//   o_c       ADD: carry-out; SUB/CMP: borrow (a < b unsigned); others 0
// ---------------------------------------------------------------------------
module rf_exec_alu
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [OPW-1:0] i_op,
  input  logic [DW-1:0]  i_a,
  input  logic [DW-1:0]  i_b,
  input  logic [DW-1:0]  i_imm,
  output logic [DW-1:0]  o_result,
  output logic           o_z,
  output logic           o_c
);

  // Arithmetic is done one bit wider; bit DW is the carry (ADD) or the
  // borrow (SUB/CMP), since a zero-extended a-b goes negative iff a < b.
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_res;
  logic          w_c;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
      end
      OP_SUB, OP_CMP: begin
        w_res = w_diff[DW-1:0];
        w_c   = w_diff[DW];
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_MOV:  w_res = i_a;
      OP_LDI:  w_res = i_imm;
      default: w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_z      = (w_res == '0);
  assign o_c      = w_c;

endmodule

// File: rtl/rf_exec_seq.sv
// ---------------------------------------------------------------------------
// rf_exec_seq
// Initiator-side sequencer for an 8x8 register file. Accepts one reg-reg
// command, reads both operands, computes the result, writes it back once
// (except CMP) and returns a response. One command in flight at a time.
//
// Handshakes (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. The initiator holds valid and payload stable
// until that edge; ready may depend combinationally on state and rst_n but
// never on valid. rsp_valid and rsp_* stay constant until the transfer.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE, out of reset)
//   cmd_op/rs/rt/rd/imm   command payload, latched on acceptance
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/z/c          result and flags
//   rf_ra/rf_rb           regfile read addresses
//   rf_rd_a/rf_rd_b       regfile combinational read data
//   rf_wa/rf_wd/rf_we     regfile write port (rf_we one cycle per command)
//   dbg_state             current FSM state
// ---------------------------------------------------------------------------
module rf_exec_seq
  import rf_exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [AW-1:0]  cmd_rs,
  input  logic [AW-1:0]  cmd_rt,
  input  logic [AW-1:0]  cmd_rd,
  input  logic [DW-1:0]  cmd_imm,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_z,
  output logic           rsp_c,
  output logic [AW-1:0]  rf_ra,
  output logic [AW-1:0]  rf_rb,
  output logic [AW-1:0]  rf_wa,
  output logic           rf_we,
  output logic [DW-1:0]  rf_wd,
  input  logic [DW-1:0]  rf_rd_a,
  input  logic [DW-1:0]  rf_rd_b,
  output state_t         dbg_state
);

  state_t         r_state;

  // Latched command (rs/rt live in r_ra/r_rb, which drive the read ports).
  logic [OPW-1:0] r_op;
  logic [AW-1:0]  r_rd;
  logic [DW-1:0]  r_imm;

  // Operands captured at the end of READ.
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;

  // Result holding registers filled in EXEC.
  logic [DW-1:0]  r_res;
  logic           r_z;
  logic           r_c;

  // Registered outputs.
  logic           r_rsp_valid;
  logic [DW-1:0]  r_rsp_data;
  logic           r_rsp_z;
  logic           r_rsp_c;
  logic [AW-1:0]  r_ra;
  logic [AW-1:0]  r_rb;
  logic [AW-1:0]  r_wa;
  logic [DW-1:0]  r_wd;
  logic           r_we;

  logic [DW-1:0]  w_alu_res;
  logic           w_alu_z;
  logic           w_alu_c;

  rf_exec_alu #(
    .DW (DW)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm    (r_imm),
    .o_result (w_alu_res),
    .o_z      (w_alu_z),
    .o_c      (w_alu_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_c     <= 1'b0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_we        <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse set only on entry to WRITE.
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is 1 here whenever rst_n is 1, so valid alone accepts.
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_rd    <= cmd_rd;
            r_imm   <= cmd_imm;
            r_ra    <= cmd_rs;
            r_rb    <= cmd_rt;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are captured before any write, so rs==rd or rt==rd
          // uses the old register value.
          r_a     <= rf_rd_a;
          r_b     <= rf_rd_b;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_res   <= w_alu_res;
          r_z     <= w_alu_z;
          r_c     <= w_alu_c;
          r_wa    <= r_rd;
          r_wd    <= w_alu_res;
          r_we    <= op_writes(r_op);
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          // The regfile commits on this edge; the response follows.
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_res;
          r_rsp_z     <= r_z;
          r_rsp_c     <= r_c;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gating with rst_n keeps a reset asserted during WRITE from committing
  // the pending write in the same cycle.
  assign cmd_ready = (r_state == ST_IDLE) && rst_n;
  assign rf_we     = r_we && rst_n;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_z     = r_rsp_z;
  assign rsp_c     = r_rsp_c;
  assign rf_ra     = r_ra;
  assign rf_rb     = r_rb;
  assign rf_wa     = r_wa;
  assign rf_wd     = r_wd;
  assign dbg_state = r_state;

endmodule
